hazard_controller: RTL

//  Central stall/flush sequencer for the 5-stage pipeline; companion to the EX-stage forwarding mux logic.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/hazard_controller_sat_counter.sv | 19 +
 rtl/hazard_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline types and constants.
// Hazard FSM encoding and the architectural zero register.
package riscv_pkg;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_MD_START,
        HZ_MD_BUSY
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating event counter.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush sequencer.
// Load-use bubbles, MUL/DIV freeze, dmem waits, branch flushes.
module hazard_controller
    import riscv_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_is_md,
    input  logic             md_done,
    input  logic             ex_branch_taken,
    input  logic             dmem_stall,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             md_start,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TW = $clog2(MD_TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(MD_TIMEOUT - 1);

    hz_state_t     state, state_nxt;
    logic [TW-1:0] timer;
    logic          done_pend;
    logic          load_use, md_any, md_fin, md_to;

    assign load_use = id_ex_mem_read && id_ex_rd != REG_ZERO &&
        ((id_uses_rs1 && id_ex_rd == if_id_rs1) ||
         (id_uses_rs2 && id_ex_rd == if_id_rs2));

    assign md_any = md_done || done_pend;
    assign md_fin = state == HZ_MD_BUSY && md_any && !dmem_stall;
    // Timeout releases the pipe like a done so the MD op leaves EX.
    assign md_to  = state == HZ_MD_BUSY && !md_any && !dmem_stall &&
                    timer == T_MAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HZ_RUN;
            timer     <= '0;
            done_pend <= 1'b0;
            md_error  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == HZ_MD_BUSY && timer != T_MAX)
                timer <= timer + TW'(1);
            else if (state != HZ_MD_BUSY)
                timer <= '0;
            if (state != HZ_MD_BUSY || md_fin)
                done_pend <= 1'b0;
            else if (md_done)
                done_pend <= 1'b1;
            if (md_to)
                md_error <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            HZ_RUN:
                if (!dmem_stall && !ex_branch_taken && id_ex_is_md)
                    state_nxt = HZ_MD_START;
            HZ_MD_START:
                state_nxt = HZ_MD_BUSY;
            HZ_MD_BUSY:
                if (md_fin || md_to)
                    state_nxt = HZ_RUN;
            default:
                state_nxt = HZ_RUN;
        endcase
    end

    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        md_start      = 1'b0;
        unique case (state)
            HZ_RUN: begin
                if (dmem_stall) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (id_ex_is_md) begin
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_ex_stall   = 1'b1;
                    ex_mem_bubble = 1'b1;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            HZ_MD_START, HZ_MD_BUSY: begin
                md_start = state == HZ_MD_START;
                if (!(md_fin || md_to)) begin
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_ex_stall   = 1'b1;
                    ex_mem_stall  = dmem_stall;
                    ex_mem_bubble = !dmem_stall;
                end
            end
            default: ;
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_stall),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (if_id_flush),
        .cnt (flush_cnt)
    );

endmodule
